vga_scanout: RTL

// Display-side reader for the 160x120 3-bit framebuffer written by the game logic (paddle/ball plot path).

---
 rtl/vga_scanout_if.sv | 26 ++
 rtl/vga_scanout.sv | 102 ++++++++++
 2 files changed

// File: rtl/vga_scanout_if.sv
// vga_scanout_if: framebuffer read port plus VGA DAC/sync pins and frame marker.
//   master (scanout side): drives fb_addr, VGA_*, frame_start; samples fb_data
//   slave  (RAM/board side): drives fb_data; samples everything else
interface vga_scanout_if;
    logic [14:0] fb_addr;
    logic [2:0]  fb_data;
    logic        VGA_CLK;
    logic        VGA_HS;
    logic        VGA_VS;
    logic        VGA_BLANK;
    logic        VGA_SYNC;
    logic [9:0]  VGA_R;
    logic [9:0]  VGA_G;
    logic [9:0]  VGA_B;
    logic        frame_start;
    modport master (
        output fb_addr, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC,
               VGA_R, VGA_G, VGA_B, frame_start,
        input  fb_data
    );
    modport slave (
        input  fb_addr, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC,
               VGA_R, VGA_G, VGA_B, frame_start,
        output fb_data
    );
endinterface

// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing generator and 4x-scaled reader of the 160x120 3-bit framebuffer.
//   CLOCK_50  system clock; pixels advance on every other cycle (pix_en)
//   resetn    asynchronous active-low reset
//   vga       master side of vga_scanout_if: fb_addr out / fb_data in (1-cycle read latency),
//             VGA_CLK/HS/VS/BLANK/SYNC/R/G/B pins, frame_start pulse
module vga_scanout #(
    parameter int H_VIS       = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VIS       = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SCALE_SHIFT = 2,
    parameter int FB_W        = 160
) (
    input logic           CLOCK_50,
    input logic           resetn,
    vga_scanout_if.master vga
);
    localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VISL = 10'(H_VIS);
    localparam logic [9:0] V_VISL = 10'(V_VIS);
    localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic        pix_en_q, vga_clk_q, start_q, fs_q;
    logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [14:0] addr_q, addr_d;
    logic        vis0_q, hs0_q, vs0_q;
    logic        blank_q, hs_q, vs_q;
    logic [2:0]  rgb_q, rgb_d;
    logic        vis, h_end, frame_end;

    // start_q marks the first pixel slot after reset: it is treated as a frame end so the
    // first frame begins with a proper 0/0 load and frame_start, and no pixel is issued.
    always_comb begin
        h_end     = hcnt_q == H_LAST;
        frame_end = start_q || (h_end && vcnt_q == V_LAST);
        hcnt_d    = (frame_end || h_end) ? 10'd0 : hcnt_q + 10'd1;
        vcnt_d    = frame_end ? 10'd0 : h_end ? vcnt_q + 10'd1 : vcnt_q;
        vis       = hcnt_q < H_VISL && vcnt_q < V_VISL;
        // Outside the visible area the address holds, so no out-of-range read is issued.
        addr_d    = vis ? 15'(int'(vcnt_q >> SCALE_SHIFT) * FB_W + int'(hcnt_q >> SCALE_SHIFT)) : addr_q;
        rgb_d     = vis0_q ? vga.fb_data : 3'd0;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            pix_en_q  <= 1'b0;
            vga_clk_q <= 1'b0;
            start_q   <= 1'b1;
            fs_q      <= 1'b0;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            addr_q    <= '0;
            vis0_q    <= 1'b0;
            hs0_q     <= 1'b1;
            vs0_q     <= 1'b1;
            blank_q   <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            rgb_q     <= '0;
        end else begin
            pix_en_q  <= !pix_en_q;
            vga_clk_q <= pix_en_q;
            fs_q      <= pix_en_q && frame_end;
            if (pix_en_q) begin
                start_q <= 1'b0;
                hcnt_q  <= hcnt_d;
                vcnt_q  <= vcnt_d;
                // Stage 0: issue the read and delay the flags of the current counter pair.
                if (!start_q) begin
                    addr_q <= addr_d;
                    vis0_q <= vis;
                    hs0_q  <= !(hcnt_q >= HS_BEG && hcnt_q <= HS_END);
                    vs0_q  <= !(vcnt_q >= VS_BEG && vcnt_q <= VS_END);
                end
                // Stage 1: read data has returned; drive all pins together.
                blank_q <= vis0_q;
                hs_q    <= hs0_q;
                vs_q    <= vs0_q;
                rgb_q   <= rgb_d;
            end
        end
    end

    assign vga.fb_addr     = addr_q;
    assign vga.VGA_CLK     = vga_clk_q;
    assign vga.VGA_HS      = hs_q;
    assign vga.VGA_VS      = vs_q;
    assign vga.VGA_BLANK   = blank_q;
    assign vga.VGA_SYNC    = 1'b0;
    assign vga.VGA_R       = {10{rgb_q[2]}};
    assign vga.VGA_G       = {10{rgb_q[1]}};
    assign vga.VGA_B       = {10{rgb_q[0]}};
    assign vga.frame_start = fs_q;
endmodule
